// File: rtl/mac_result_serializer.sv
// ---------------------------------------------------------------------------
// mac_result_serializer
//
// Readout stage for the 8-bit signed MAC. On an accepted request it snapshots
// the accumulator word into a shift register and sends it MSB-first over a
// three-wire SPI-style link (cs_n, sclk, sdo). Each sclk phase lasts CLK_DIV
// clk cycles. Requests that arrive during a transfer set a sticky overrun flag.
//
// Optional feature macro: MAC_SER_PARITY_EN
//   defined   -> an even-parity bit (XOR of the captured word) follows the LSB
//   undefined -> exactly DATA_W bits per frame, no parity logic
//
// Parameters
//   DATA_W   width of the captured accumulator word
//   CLK_DIV  sclk half-period in clk cycles (1..255)
//
// Ports
//   clk       clock
//   rst_n     synchronous active-low reset
//   acc_in    accumulator value, sampled only on an accepted req
//   req       start request, level-sampled every edge
//   clr_ovr   clears the overrun flag (a simultaneous set wins)
//   cs_n      chip select, active-low
//   sclk      serial clock, idles low
//   sdo       serial data, changes on sclk falling edges
//   busy      transfer in progress
//   done      one-cycle pulse at end of transfer
//   ovr       sticky overrun: req seen while busy
//   snap_out  last captured acc_in
// ---------------------------------------------------------------------------
module mac_result_serializer #(
    parameter int DATA_W  = 24,
    parameter int CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] acc_in,
    input  logic              req,
    input  logic              clr_ovr,
    output logic              cs_n,
    output logic              sclk,
    output logic              sdo,
    output logic              busy,
    output logic              done,
    output logic              ovr,
    output logic [DATA_W-1:0] snap_out
);

`ifdef MAC_SER_PARITY_EN
    localparam int N = DATA_W + 1;
`else
    localparam int N = DATA_W;
`endif
    localparam int BIT_W = $clog2(N);
    localparam int DIV_W = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [N-1:0]      shreg_q, shreg_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              sdo_q, sdo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic [DATA_W-1:0] snap_q, snap_d;

    logic              div_last;
    logic [N-1:0]      capture;

    // Word loaded into the shift register; the frame always leaves from
    // shreg[N-1], so the parity bit simply rides in the LSB position.
`ifdef MAC_SER_PARITY_EN
    assign capture = {acc_in, ^acc_in};
`else
    assign capture = acc_in;
`endif

    assign div_last = (div_q == DIV_LAST);

    // NOTE: every _d gets a default before the case statement; any path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        div_d   = (state_q == IDLE || div_last) ? '0 : div_q + DIV_W'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        sdo_d   = sdo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        snap_d  = snap_q;

        // Set has priority over clear; the transfer itself ignores overruns.
        if (req && busy_q) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    shreg_d = capture;
                    snap_d  = acc_in;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    sdo_d   = acc_in[DATA_W-1];
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_last) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    sclk_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        sdo_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        // The bit now in shreg[N-1] was just sampled; present
                        // the next one on this falling edge.
                        sdo_d   = shreg_q[N-2];
                        shreg_d = shreg_q << 1;
                        bit_d   = bit_q + BIT_W'(1);
                        state_d = SHIFT_LO;
                    end
                end
            end
            SHIFT_LO: begin
                if (div_last) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT_HI;
                end
            end
            HOLD: begin
                if (div_last) begin
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the shift register is reset along with the control state;
            // it is a plain flop chain, not a RAM, so the reset is cheap and
            // keeps the frame contents deterministic after an abort.
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            snap_q  <= snap_d;
        end
    end

    assign cs_n     = cs_n_q;
    assign sclk     = sclk_q;
    assign sdo      = sdo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ovr      = ovr_q;
    assign snap_out = snap_q;

endmodule

// File: tb/tb_mac_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_mac_result_serializer
//
// Two serializer instances (CLK_DIV=1 and CLK_DIV=3) share reset, acc_in and
// clr_ovr; each has its own req. Expected wire activity is computed from the
// frame timeline: sclk rise k at E0+D*(2k-1), fall at E0+2kD, done at
// E0+D*(2N+1), with the bit sequence taken from the captured value.
// Honours MAC_SER_PARITY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_mac_result_serializer;

    localparam int DATA_W = 24;
`ifdef MAC_SER_PARITY_EN
    localparam int N = DATA_W + 1;
`else
    localparam int N = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] acc_in;
    logic [1:0]        req_v;
    logic              clr_ovr;

    logic              cs_n0, sclk0, sdo0, busy0, done0, ovr0;
    logic              cs_n1, sclk1, sdo1, busy1, done1, ovr1;
    logic [DATA_W-1:0] snap0, snap1;

    int total = 0;
    int bad   = 0;
    int frame_no = 0;
    int idle_no  = 0;
    bit exp_ovr [2];

    always #5 clk = ~clk;

    mac_result_serializer #(.DATA_W(DATA_W), .CLK_DIV(1)) u_div1 (
        .clk(clk), .rst_n(rst_n), .acc_in(acc_in), .req(req_v[0]), .clr_ovr(clr_ovr),
        .cs_n(cs_n0), .sclk(sclk0), .sdo(sdo0), .busy(busy0), .done(done0),
        .ovr(ovr0), .snap_out(snap0)
    );

    mac_result_serializer #(.DATA_W(DATA_W), .CLK_DIV(3)) u_div3 (
        .clk(clk), .rst_n(rst_n), .acc_in(acc_in), .req(req_v[1]), .clr_ovr(clr_ovr),
        .cs_n(cs_n1), .sclk(sclk1), .sdo(sdo1), .busy(busy1), .done(done1),
        .ovr(ovr1), .snap_out(snap1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // {cs_n, sclk, sdo, busy, done, ovr}
    function automatic logic [5:0] vec(input int i);
        return (i == 0) ? {cs_n0, sclk0, sdo0, busy0, done0, ovr0}
                        : {cs_n1, sclk1, sdo1, busy1, done1, ovr1};
    endfunction

    function automatic logic [DATA_W-1:0] snap(input int i);
        return (i == 0) ? snap0 : snap1;
    endfunction

    // Overrun model for the coming edge: set by req while busy, else cleared
    // by clr_ovr. Only the selected instance can be busy.
    function automatic void step_ovr(input int sel, input bit busy_now);
        for (int i = 0; i < 2; i++) begin
            if (req_v[i] && (i == sel) && busy_now) exp_ovr[i] = 1'b1;
            else if (clr_ovr)                        exp_ovr[i] = 1'b0;
        end
    endfunction

    task automatic idle_cycles(input int n, input bit clr);
        for (int k = 0; k < n; k++) begin
            req_v   = 2'b00;
            clr_ovr = clr;
            step_ovr(0, 1'b0);
            @(negedge clk);
            idle_no++;
            for (int i = 0; i < 2; i++)
                check($sformatf("idle%0d dut%0d", idle_no, i), vec(i), {5'b10000, exp_ovr[i]});
        end
        clr_ovr = 1'b0;
    endtask

    // Runs one frame on instance sel. Optional events, relative to E0 (-1 = none):
    // pulse_t: extra req at that edge; clr_t: clr_ovr at that edge;
    // chg_t: acc_in changes at that edge; rst_t: reset at that edge.
    // hold keeps req high through the frame and on return.
    task automatic run_frame(input int sel, input logic [DATA_W-1:0] value,
                             input int pulse_t, input int clr_t, input int chg_t,
                             input int rst_t, input bit hold);
        int d, last, nrx;
        bit bits [N];
        logic [N-1:0] exp_word, rx;
        logic e_cs, e_sclk, e_sdo, e_busy, e_done, prev_sclk;
        logic [5:0] got;
        string tag;

        d    = (sel == 0) ? 1 : 3;
        last = (2 * N + 1) * d;
        for (int j = 0; j < DATA_W; j++) bits[j] = value[DATA_W-1-j];
`ifdef MAC_SER_PARITY_EN
        bits[DATA_W] = ($countones(value) % 2) == 1;
`endif
        exp_word = '0;
        for (int j = 0; j < N; j++) exp_word = {exp_word[N-2:0], bits[j]};

        frame_no++;
        acc_in     = value;
        req_v      = 2'b00;
        req_v[sel] = 1'b1;
        clr_ovr    = 1'b0;
        step_ovr(sel, 1'b0);
        @(posedge clk);  // E0
        nrx = 0;
        rx = '0;
        prev_sclk = 1'b0;
        for (int t = 0; t <= last; t++) begin
            @(negedge clk);
            tag = $sformatf("frame%0d dut%0d t=%0d", frame_no, sel, t);
            if (t == rst_t) begin
                exp_ovr[0] = 1'b0;
                exp_ovr[1] = 1'b0;
                check({tag, " reset"}, vec(sel), 6'b100000);
                check({tag, " reset snap"}, snap(sel), '0);
                rst_n   = 1'b1;
                req_v   = 2'b00;
                clr_ovr = 1'b0;
                idle_cycles(3, 1'b0);
                return;
            end
            e_cs   = (t >= last);
            e_busy = (t < last);
            e_done = (t == last);
            e_sclk = (t >= d && t < 2 * N * d) ? ((t / d) % 2 == 1) : 1'b0;
            e_sdo  = (t < 2 * N * d) ? bits[t / (2 * d)] : 1'b0;
            got = vec(sel);
            check(tag, got, {e_cs, e_sclk, e_sdo, e_busy, e_done, exp_ovr[sel]});
            // Receiver view: capture sdo on each sclk rise.
            if (got[4] && !prev_sclk) begin
                rx = {rx[N-2:0], got[3]};
                nrx++;
            end
            prev_sclk = got[4];
            if (t == last) break;
            req_v[sel] = hold || (t + 1 == pulse_t);
            clr_ovr    = (t + 1 == clr_t);
            if (t + 1 == chg_t) acc_in = DATA_W'($urandom);
            if (t + 1 == rst_t) rst_n = 1'b0;
            step_ovr(sel, e_busy);
        end
        check($sformatf("frame%0d rx word", frame_no), rx, exp_word);
        check($sformatf("frame%0d rx bits", frame_no), nrx, N);
        check($sformatf("frame%0d snap", frame_no), snap(sel), value);
        clr_ovr = 1'b0;
        if (!hold) req_v = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sel, last;
        rst_n      = 1'b0;
        req_v      = 2'b00;
        clr_ovr    = 1'b0;
        acc_in     = '0;
        exp_ovr[0] = 1'b0;
        exp_ovr[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset dut%0d", i), vec(i), 6'b100000);
            check($sformatf("reset snap dut%0d", i), snap(i), '0);
        end
        rst_n = 1'b1;
        idle_cycles(2, 1'b0);

        // Basic frame and divided negative value.
        run_frame(0, 24'hA50F3C, -1, -1, -1, -1, 1'b0);
        idle_cycles(2, 1'b0);
        run_frame(1, 24'hFFFF80, -1, -1, -1, -1, 1'b0);
        idle_cycles(2, 1'b0);

        // Overrun: set mid-frame, set+clear keeps it, clear alone drops it.
        run_frame(0, DATA_W'($urandom), 10, -1, -1, -1, 1'b0);
        run_frame(0, DATA_W'($urandom), 12, 12, -1, -1, 1'b0);
        idle_cycles(1, 1'b1);
        idle_cycles(1, 1'b0);

        // Reset mid-frame, then a clean frame.
        run_frame(0, DATA_W'($urandom), -1, -1, -1, 20, 1'b0);
        run_frame(0, 24'h000001, -1, -1, -1, -1, 1'b0);
        idle_cycles(2, 1'b0);

        // Back-to-back with req held and acc_in changing mid-frame.
        run_frame(0, DATA_W'($urandom), -1, -1, 5, -1, 1'b1);
        run_frame(0, DATA_W'($urandom), -1, -1, 7, -1, 1'b0);
        idle_cycles(1, 1'b1);

        // Randomized frames on either divider.
        for (int r = 0; r < 8; r++) begin
            sel  = int'($urandom_range(0, 1));
            last = (2 * N + 1) * ((sel == 0) ? 1 : 3);
            run_frame(sel, DATA_W'($urandom),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, last)) : -1,
                      -1, int'($urandom_range(1, last)), -1, 1'b0);
            idle_cycles(1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_result_serializer.md
# mac_result_serializer

Downstream readout stage for the 8-bit signed MAC. On request it snapshots the 24-bit accumulator value into a shift register and sends it MSB-first over a three-wire SPI-style link (cs_n, sclk, sdo) with a programmable bit rate. This lets off-chip logic read the full accumulator without three byte-select reads. It also reports busy/done and flags requests that arrive while a transfer is in progress.

## Interface
- DATA_W, 24: width of the accumulator word captured and shifted.
- CLK_DIV, 1: sclk half-period in clk cycles. Legal range 1..255.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- acc_in  in  DATA_W  accumulator value, two's complement; sampled only on accepted req.
- req  in  1  start request; level-sampled each clk edge.
- clr_ovr  in  1  clears the overrun flag.
- cs_n  out  1  chip select, active-low; reset 1.
- sclk  out  1  serial clock, idle low; reset 0.
- sdo  out  1  serial data; reset 0.
- busy  out  1  transfer in progress; reset 0.
- done  out  1  one-cycle pulse at end of transfer; reset 0.
- ovr  out  1  sticky: req seen while busy; reset 0.
- snap_out  out  DATA_W  last captured acc_in; reset 0.

## Operation
- All outputs are registered. N = number of bits shifted: DATA_W, or DATA_W+1 with parity (see Configuration).
- FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD. A divider counter counts 0..CLK_DIV-1 in every non-IDLE state.
- IDLE: cs_n=1, sclk=0, sdo=0, busy=0. If req=1 at an edge:
  - shreg<=acc_in and snap_out<=acc_in.
  - cs_n<=0, busy<=1, sdo<=acc_in[DATA_W-1].
  - Next state SETUP.
- SETUP: sclk=0 for CLK_DIV cycles, then sclk<=1 and go to SHIFT_HI.
- SHIFT_HI: sclk=1 for CLK_DIV cycles, then sclk<=0.
  - If bits remain: sdo<=next bit and go to SHIFT_LO.
  - After bit N: sdo<=0 and go to HOLD.
- SHIFT_LO: sclk=0 for CLK_DIV cycles, then sclk<=1 and go to SHIFT_HI.
- HOLD: cs_n stays low for CLK_DIV cycles. Then cs_n<=1, busy<=0, done<=1 (one cycle), and go to IDLE.
- Bit order: MSB first, shreg[DATA_W-1] down to shreg[0], then the parity bit if enabled. sdo changes only on sclk falling edges (and at the initial capture); the receiver samples on sclk rising.
- No arithmetic is done on data; the sign bit is transmitted as is.
- Overrun:
  - req=1 while busy=1 sets ovr<=1; the transfer continues unaffected and shreg/snap_out are not modified.
  - clr_ovr=1 clears ovr.
  - If set and clear occur in the same cycle, set wins.
- req held high continuously: a new transfer starts at the first edge in IDLE; ovr is set by every busy cycle in which req is high.
- Reset mid-transfer: the next rising edge with rst_n=0 forces every output to its reset value and the state to IDLE. No done pulse is produced and the partial frame is abandoned.

## Timing
- Let E0 be the edge that accepts req.
- cs_n falls and sdo presents the MSB at E0.
- The k-th sclk rise (k=1..N) occurs at E0+CLK_DIV*(2k-1); the k-th sclk fall occurs at E0+CLK_DIV*2k.
- cs_n rises, busy falls and done pulses at E0+CLK_DIV*(2N+1), lasting exactly one clk cycle.
- Example: CLK_DIV=1, N=24 gives 49 cycles.
- The earliest next acceptance is the edge after done rises (req sampled while done=1 is accepted).
- Latency from acc_in to the wire: acc_in is sampled at E0 only; later changes to acc_in do not affect the frame in progress.

## Configuration
- MAC_SER_PARITY_EN defined: one even-parity bit (XOR of all DATA_W captured bits) is appended after the LSB, so N=DATA_W+1. Its sclk fall drives sdo<=0 and enters HOLD.
- MAC_SER_PARITY_EN undefined: no parity bit, N=DATA_W; all parity logic is absent.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> cs_n=1, sclk=0, sdo=0, busy=0, done=0, ovr=0, snap_out=0.
- Basic frame: CLK_DIV=1, acc_in=24'hA50F3C, one-cycle req -> 24 bits 1010_0101_0000_1111_0011_1100 on sclk rises; done at E0+49; snap_out=24'hA50F3C. With parity enabled, a 25th bit 0 is sent and done occurs at E0+51.
- Divider and negative value: CLK_DIV=3, acc_in=24'hFFFF80 -> each sclk phase lasts 3 cycles; bits are sixteen 1s, then 1000_0000; parity bit 1 if enabled; done at E0+147 (+6 with parity).
- Overrun: pulse req at E0+10 mid-frame -> ovr=1, frame data unchanged. Assert clr_ovr together with another busy req -> ovr stays 1. clr_ovr alone -> ovr=0.
- Reset mid-frame: rst_n=0 at E0+20 -> all outputs reset on that edge, no done pulse. A subsequent req with 24'h000001 sends twenty-three 0s then a 1 (parity 1 if enabled).
- Back-to-back: req held high -> the second frame's cs_n falls at the edge after the done cycle. acc_in is changed mid-frame -> the first frame's bits and snap_out are unaffected.
